univ_shift_reg_n: RTL
=====================

Name: univ_shift_reg_n

Overview:
Parametrised universal shift register, the successor to the 4-bit bidirectional shift register. Adds generic width, parallel load, rotate and arithmetic modes, and a multi-step burst engine with a busy/done handshake. The burst engine shifts by `shamt` positions, one position per clock. Used as a serialiser/deserialiser and as a barrel-shift substitute in datapath blocks.

Parameters:
- WIDTH, 8, register width in bits (>= 2).
- CNT_W, 4, width of the `shamt` burst step count.
- RESET_VAL, 0, value loaded into `q` on `clr`.

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  synchronous, active-high reset.
- en  in  1  enables a single-step operation in IDLE.
- mode  in  3  operation select (see Behaviour).
- dr  in  1  serial input for right shift, enters at q[WIDTH-1].
- dl  in  1  serial input for left shift, enters at q[0].
- din  in  WIDTH  parallel load data.
- start  in  1  request a burst of `shamt` steps.
- shamt  in  CNT_W  burst step count.
- q  out  WIDTH  register contents.
- so_r  out  1  right serial out, combinational = q[0].
- so_l  out  1  left serial out, combinational = q[WIDTH-1].
- busy  out  1  high while a burst is in progress.
- done  out  1  one-cycle pulse at burst completion.

Behaviour:
- Reset: `clr`=1 at a clock edge sets q=RESET_VAL, busy=0, done=0, state=IDLE and counter=0.
  - `clr` has priority over every other input and aborts any burst in progress.
- Mode encoding:
  - 000 HOLD.
  - 001 SHR: q <= {dr, q[WIDTH-1:1]}.
  - 010 SHL: q <= {q[WIDTH-2:0], dl}.
  - 011 LOAD: q <= din.
  - 100 ROR.
  - 101 ROL.
  - 110 ASR: MSB replicated; `dr` ignored.
  - 111 reserved, behaves as HOLD.
- States: IDLE and BURST.
- IDLE, start=0:
  - en=1: one step of `mode` per edge.
  - en=0: q holds.
- IDLE, start=1 (accepted regardless of `en`):
  - shamt=0: q unchanged, done=1 for the next cycle, busy stays 0, state stays IDLE.
  - mode in {000, 011, 111}: execute that operation once on this edge, done=1 next cycle, state stays IDLE.
  - Otherwise (edge E0): latch mode into mode_r, cnt <= shamt, busy <= 1, state -> BURST. q is unchanged at E0.
- BURST, each edge E1..En (n=shamt):
  - Perform one step of mode_r. `dr`/`dl` are sampled live each edge.
  - cnt decrements.
  - At the edge where cnt==1: state -> IDLE, busy <= 0, done <= 1.
- Timing:
  - done is high for exactly one cycle, concurrent with the final q value.
  - Burst latency from accept to done is shamt+1 edges.
- During BURST, `en`, `mode`, `start`, `din` and `shamt` are ignored. A start asserted while busy=1 is dropped, not queued.
- done is cleared on the edge after it asserts, unless a new zero-length or single-op start is accepted that edge, in which case it re-asserts.
- shamt > WIDTH is legal. Rotates wrap modulo WIDTH, shifts fully flush the register.
- `so_r` and `so_l` are purely combinational from q and are valid in every state.

Test Plan:
1. Reset: apply clr=1 for 2 cycles with start=1, en=1, mode=011 -> q=00, busy=0, done=0. clr has priority.
2. Single steps (WIDTH=8):
   - LOAD din=A5, en=1 -> q=A5.
   - SHR with dr=1 -> q=D2, so_r=0.
   - SHL with dl=0 -> q=A4, so_l=1.
   - en=0 -> q holds A4.
3. ROL burst: q=81, start=1, mode=101, shamt=3.
   - busy=1 for 3 cycles; q steps 81 -> 03 -> 06 -> 0C.
   - done=1 exactly on the cycle q=0C; busy=0 on the same cycle.
4. ASR burst and zero-length start:
   - q=90, mode=110, shamt=2, dr=0 -> q steps C8 -> E4, then done pulses.
   - Next, start with shamt=0 -> q=E4 unchanged, done pulses 1 cycle, busy never asserts.
5. Abort and dropped start: ROR burst shamt=5 from q=F0.
   - Assert start again after 1 step -> ignored.
   - Assert clr after 2 steps -> q=00, busy=0, done never pulses. Next start is accepted normally.
6. Wrap: q=01, ROR burst shamt=10 -> q=40 after 10 steps, done pulses once. SHR burst shamt=12 with dr=0 -> q=00.

Source files
------------

// File: rtl/univ_shift_reg_n_if.sv
// rtl/univ_shift_reg_n_if.sv - control/data bundle for the universal shift register
interface univ_shift_reg_n_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             en;
    logic [2:0]       mode;
    logic             dr;
    logic             dl;
    logic [WIDTH-1:0] din;
    logic             start;
    logic [CNT_W-1:0] shamt;
    logic [WIDTH-1:0] q;
    logic             so_r;
    logic             so_l;
    logic             busy;
    logic             done;

    modport master (
        output en, mode, dr, dl, din, start, shamt,
        input  q, so_r, so_l, busy, done
    );

    modport slave (
        input  en, mode, dr, dl, din, start, shamt,
        output q, so_r, so_l, busy, done
    );
endinterface

// File: rtl/univ_shift_reg_n.sv
// rtl/univ_shift_reg_n.sv - universal shift register with multi-step burst engine
module univ_shift_reg_n #(
    parameter int               WIDTH     = 8,
    parameter int               CNT_W     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                clk,
    input  logic                clr,
    univ_shift_reg_n_if.slave   bus
);
    typedef enum logic {IDLE, BURST} state_t;

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_SHR  = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_LOAD = 3'b011;
    localparam logic [2:0] M_ROR  = 3'b100;
    localparam logic [2:0] M_ROL  = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;

    state_t           state, state_n;
    logic [WIDTH-1:0] q_r, q_n;
    logic [2:0]       mode_r, mode_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             busy_r, busy_n;
    logic             done_r, done_n;

    // One position of the selected operation; reserved 111 falls through to hold
    function automatic logic [WIDTH-1:0] step(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] v,
        input logic             sr,
        input logic             sl,
        input logic [WIDTH-1:0] d
    );
        case (m)
            M_SHR:   step = {sr, v[WIDTH-1:1]};
            M_SHL:   step = {v[WIDTH-2:0], sl};
            M_LOAD:  step = d;
            M_ROR:   step = {v[0], v[WIDTH-1:1]};
            M_ROL:   step = {v[WIDTH-2:0], v[WIDTH-1]};
            M_ASR:   step = {v[WIDTH-1], v[WIDTH-1:1]};
            default: step = v;
        endcase
    endfunction

    // State and datapath registers; clr wins over everything, including a running burst
    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= IDLE;
            q_r    <= RESET_VAL;
            mode_r <= M_HOLD;
            cnt    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state  <= state_n;
            q_r    <= q_n;
            mode_r <= mode_n;
            cnt    <= cnt_n;
            busy_r <= busy_n;
            done_r <= done_n;
        end
    end

    // Next-state logic: single steps and burst acceptance in IDLE, counted steps in BURST
    always_comb begin
        state_n = state;
        q_n     = q_r;
        mode_n  = mode_r;
        cnt_n   = cnt;
        busy_n  = busy_r;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.shamt == '0) begin
                        done_n = 1'b1;
                    end else if (bus.mode == M_HOLD || bus.mode == M_LOAD || bus.mode == 3'b111) begin
                        // Non-shifting ops gain nothing from repetition: do it once
                        q_n    = step(bus.mode, q_r, bus.dr, bus.dl, bus.din);
                        done_n = 1'b1;
                    end else begin
                        mode_n  = bus.mode;
                        cnt_n   = bus.shamt;
                        busy_n  = 1'b1;
                        state_n = BURST;
                    end
                end else if (bus.en) begin
                    q_n = step(bus.mode, q_r, bus.dr, bus.dl, bus.din);
                end
            end
            BURST: begin
                // Serial inputs are sampled live on every burst edge
                q_n   = step(mode_r, q_r, bus.dr, bus.dl, bus.din);
                cnt_n = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.q    = q_r;
    assign bus.so_r = q_r[0];
    assign bus.so_l = q_r[WIDTH-1];
    assign bus.busy = busy_r;
    assign bus.done = done_r;
endmodule
